// File: rtl/rr_mux_pkg.sv
// rr_mux_pkg: shared types and constants for the rr_mux_arb block.
//   st_t       - output-slot state (EMPTY / FULL)
//   MODE_*     - encodings of the mode input
//   DEF_*      - default channel count and data width
package rr_mux_pkg;
  localparam int   DEF_N_CH   = 8;
  localparam int   DEF_DATA_W = 8;
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} st_t;
endpackage

// File: rtl/rr_mux_pick.sv
// rr_mux_pick: combinational grant selection for rr_mux_arb.
//   ptr         - round-robin scan start
//   in_valid    - per-channel requests
//   mode        - MODE_FIXED: grant sel if it requests; MODE_RR: first requester from ptr
//   sel         - fixed-mode channel index (out-of-range gives no grant)
//   grant_valid - a channel is granted
//   grant_idx   - granted channel index
module rr_mux_pick
  import rr_mux_pkg::*;
#(
  parameter int N_CH  = DEF_N_CH,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic [SEL_W-1:0] ptr,
  input  logic [N_CH-1:0]  in_valid,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  output logic             grant_valid,
  output logic [SEL_W-1:0] grant_idx
);
  localparam logic [SEL_W:0] NCH = (SEL_W+1)'(N_CH);

  logic [2*N_CH-1:0] dbl;
  logic [N_CH-1:0]   rot;
  logic [SEL_W-1:0]  off;
  logic [SEL_W:0]    sum;
  logic              rr_hit;
  logic              fx_hit;

  // Rotate requests so bit 0 is channel ptr; the lowest set bit is the winner.
  assign dbl = {in_valid, in_valid} >> ptr;
  assign rot = dbl[N_CH-1:0];

  always_comb begin
    off    = '0;
    rr_hit = 1'b0;
    for (int i = N_CH-1; i >= 0; i--) begin
      if (rot[i]) begin
        off    = SEL_W'(i);
        rr_hit = 1'b1;
      end
    end
  end

  assign sum = {1'b0, ptr} + {1'b0, off};

  // Compare against every legal index so sel >= N_CH never matches.
  always_comb begin
    fx_hit = 1'b0;
    for (int k = 0; k < N_CH; k++)
      if (sel == SEL_W'(k)) fx_hit = in_valid[k];
  end

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    if (mode == MODE_RR) begin
      grant_valid = rr_hit;
      grant_idx   = (sum >= NCH) ? SEL_W'(sum - NCH) : SEL_W'(sum);
    end else begin
      grant_valid = fx_hit;
      grant_idx   = sel;
    end
  end
endmodule

// File: rtl/rr_mux_arb.sv
// rr_mux_arb: N-channel registered mux with valid/ready on every port.
// Fixed-select or round-robin grant feeds a single output register slot.
//   clk, rst_n          - clock, async active-low reset
//   mode, sel           - grant mode and fixed-mode channel
//   in_data/in_valid    - channel k data at [k*DATA_W +: DATA_W]
//   in_ready            - one-hot (or zero) accept
//   out_data/out_valid  - registered output; out_ready is consumer accept
//   out_ch              - source channel, only with RR_MUX_CHID_EN defined
module rr_mux_arb
  import rr_mux_pkg::*;
#(
  parameter  int N_CH   = DEF_N_CH,
  parameter  int DATA_W = DEF_DATA_W,
  localparam int SEL_W  = $clog2(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   mode,
  input  logic [SEL_W-1:0]       sel,
  input  logic [N_CH*DATA_W-1:0] in_data,
  input  logic [N_CH-1:0]        in_valid,
  output logic [N_CH-1:0]        in_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_valid,
`ifdef RR_MUX_CHID_EN
  output logic [SEL_W-1:0]       out_ch,
`endif
  input  logic                   out_ready
);
  logic [N_CH-1:0][DATA_W-1:0] in_vec;
  logic [SEL_W-1:0]            ptr;
  logic                        grant_valid;
  logic [SEL_W-1:0]            grant_idx;
  logic                        load, xfer_in, xfer_out;
  st_t                         st, st_nxt;

  assign in_vec = in_data;

  rr_mux_pick #(.N_CH(N_CH), .SEL_W(SEL_W)) u_pick (
    .ptr         (ptr),
    .in_valid    (in_valid),
    .mode        (mode),
    .sel         (sel),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign out_valid = (st == FULL);
  assign load      = !out_valid || out_ready;
  // rst_n gate keeps in_ready low for the whole reset window.
  assign xfer_in   = rst_n && load && grant_valid;
  assign xfer_out  = out_valid && out_ready;

  for (genvar k = 0; k < N_CH; k++) begin : g_rdy
    assign in_ready[k] = xfer_in && (grant_idx == SEL_W'(k));
  end

  always_comb begin
    st_nxt = st;
    case (st)
      EMPTY:   if (xfer_in) st_nxt = FULL;
      FULL:    if (xfer_out && !xfer_in) st_nxt = EMPTY;
      default: st_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= EMPTY;
      out_data <= '0;
      ptr      <= '0;
    end else begin
      st <= st_nxt;
      if (xfer_in) begin
        out_data <= in_vec[grant_idx];
        if (mode == MODE_RR)
          ptr <= (grant_idx == SEL_W'(N_CH-1)) ? '0 : grant_idx + 1'b1;
      end
    end
  end

`ifdef RR_MUX_CHID_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       out_ch <= '0;
    else if (xfer_in) out_ch <= grant_idx;
  end
`endif
endmodule

// File: tb/tb_rr_mux_arb.sv
// tb_rr_mux_arb: directed + randomized bench for rr_mux_arb (N_CH=8, DATA_W=8).
// Reference model: one-slot buffer with integer round-robin pointer.
module tb_rr_mux_arb;
  localparam int N = 8, W = 8, SW = 3;

  logic          clk = 1'b0, rst_n = 1'b0, mode = 1'b0, out_ready = 1'b0;
  logic [SW-1:0] sel = '0;
  logic [N*W-1:0] in_data = '0;
  logic [N-1:0]  in_valid = '0;
  logic [N-1:0]  in_ready;
  logic [W-1:0]  out_data;
  logic          out_valid;
`ifdef RR_MUX_CHID_EN
  logic [SW-1:0] out_ch;
`endif

  int n_chk = 0, n_fail = 0;

  // model state
  bit       m_full = 0;
  logic [W-1:0] m_data = '0;
  int       m_ptr = 0, m_ch = 0;

  always #5 clk = ~clk;

  rr_mux_arb #(.N_CH(N), .DATA_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid),
`ifdef RR_MUX_CHID_EN
    .out_ch(out_ch),
`endif
    .out_ready(out_ready)
  );

  function automatic int grant_of();
    if (!rst_n) return -1;
    if (m_full && !out_ready) return -1;
    if (mode == 1'b0) return in_valid[sel] ? int'(sel) : -1;
    for (int i = 0; i < N; i++) begin
      int k = (m_ptr + i) % N;
      if (in_valid[k]) return k;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] ready_of(input int g);
    logic [N-1:0] r = '0;
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic set_data(input logic [W-1:0] base);
    for (int k = 0; k < N; k++) in_data[k*W +: W] = base + W'(k);
  endtask

  task automatic drive(input bit md, input int s, input logic [N-1:0] v, input bit ordy);
    @(negedge clk);
    mode = md; sel = SW'(s); in_valid = v; out_ready = ordy;
    #1;
  endtask

  // advance one edge, updating the model alongside the DUT
  task automatic step();
    int g = grant_of();
    @(posedge clk);
    if (g >= 0) begin
      m_full = 1; m_data = in_data[g*W +: W]; m_ch = g;
      if (mode) m_ptr = (g + 1) % N;
    end else if (m_full && out_ready) m_full = 0;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    mode = 1; in_valid = 8'hFF; out_ready = 1; set_data(8'h10);
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_chk++; if (in_ready !== 8'h00) begin n_fail++; $display("FAIL reset_in_ready got=%h exp=00", in_ready); end
    n_chk++; if (dut.ptr !== 3'd0) begin n_fail++; $display("FAIL reset_ptr got=%0d exp=0", dut.ptr); end
    n_chk++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
    @(negedge clk);
    in_valid = '0; rst_n = 1;
    m_full = 0; m_ptr = 0; m_data = '0; m_ch = 0;
    step();
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_out_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_fixed_sweep();
    set_data(8'hA0);
    for (int s = 0; s < N; s++) begin
      drive(0, s, 8'hFF, 1);
      n_chk++; if (in_ready !== ready_of(s)) begin n_fail++; $display("FAIL fixed_ready sel=%0d got=%h exp=%h", s, in_ready, ready_of(s)); end
      step();
      n_chk++; if (out_valid !== 1'b1 || out_data !== 8'hA0 + W'(s)) begin
        n_fail++; $display("FAIL fixed_data sel=%0d got=%b/%h exp=1/%h", s, out_valid, out_data, 8'hA0 + W'(s)); end
    end
  endtask

  task automatic test_rr_all();
    // fixed mode left the pointer at 0
    for (int i = 0; i <= N; i++) begin
      drive(1, 0, 8'hFF, 1);
      n_chk++; if (in_ready !== ready_of(i % N)) begin n_fail++; $display("FAIL rr_all_ready i=%0d got=%h exp=%h", i, in_ready, ready_of(i % N)); end
      step();
      n_chk++; if (out_valid !== 1'b1 || out_data !== 8'hA0 + W'(i % N)) begin
        n_fail++; $display("FAIL rr_all_data i=%0d got=%b/%h exp=1/%h", i, out_valid, out_data, 8'hA0 + W'(i % N)); end
    end
  endtask

  task automatic test_rr_sparse();
    int exp_g[3] = '{7, 1, 7};
    drive(1, 0, 8'b0000_0010, 1);   // grant 1 -> ptr = 2
    step();
    n_chk++; if (dut.ptr !== 3'd2) begin n_fail++; $display("FAIL sparse_ptr got=%0d exp=2", dut.ptr); end
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 8'b1000_0010, 1);
      n_chk++; if (in_ready !== ready_of(exp_g[i])) begin n_fail++; $display("FAIL sparse_ready i=%0d got=%h exp=%h", i, in_ready, ready_of(exp_g[i])); end
      step();
      n_chk++; if (out_data !== 8'hA0 + W'(exp_g[i])) begin n_fail++; $display("FAIL sparse_data i=%0d got=%h exp=%h", i, out_data, 8'hA0 + W'(exp_g[i])); end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] held;
    int c0;
    drive(1, 0, 8'hFF, 1);
    step();
    held = out_data;
    c0 = int'(held - 8'hA0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 8'hFF, 0);
      n_chk++; if (in_ready !== 8'h00) begin n_fail++; $display("FAIL bp_ready i=%0d got=%h exp=00", i, in_ready); end
      step();
      n_chk++; if (out_valid !== 1'b1 || out_data !== held) begin n_fail++; $display("FAIL bp_hold i=%0d got=%b/%h exp=1/%h", i, out_valid, out_data, held); end
    end
    // after release: channels continue c0+1, c0+2, ... with nothing skipped or repeated
    for (int i = 1; i <= N; i++) begin
      drive(1, 0, 8'hFF, 1);
      step();
      n_chk++; if (out_data !== 8'hA0 + W'((c0 + i) % N)) begin
        n_fail++; $display("FAIL bp_seq i=%0d got=%h exp=%h", i, out_data, 8'hA0 + W'((c0 + i) % N)); end
    end
  endtask

  task automatic test_no_grant();
    drive(0, 3, 8'hF7, 1);
    n_chk++; if (in_ready !== 8'h00) begin n_fail++; $display("FAIL nogrant_ready got=%h exp=00", in_ready); end
    step();
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL nogrant_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_full();
    drive(0, 5, 8'hFF, 0);
    step();
    n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rstfull_load got=%b exp=1", out_valid); end
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    m_full = 0; m_ptr = 0; m_data = '0; m_ch = 0;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstfull_valid got=%b exp=0", out_valid); end
    n_chk++; if (in_ready !== 8'h00) begin n_fail++; $display("FAIL rstfull_ready got=%h exp=00", in_ready); end
    @(posedge clk); #1;
    n_chk++; if (out_valid !== 1'b0 || out_data !== 8'h00) begin n_fail++; $display("FAIL rstfull_hold got=%b/%h exp=0/00", out_valid, out_data); end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      logic [N-1:0] exp_r;
      @(negedge clk);
      mode = 1'($urandom_range(0, 1));
      sel = SW'($urandom_range(0, N-1));
      in_valid = N'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < N; k++) in_data[k*W +: W] = W'($urandom);
      #1;
      exp_r = ready_of(grant_of());
      n_chk++; if (in_ready !== exp_r) begin n_fail++; $display("FAIL rand_ready c=%0d got=%h exp=%h", c, in_ready, exp_r); end
      step();
      n_chk++; if (out_valid !== m_full) begin n_fail++; $display("FAIL rand_valid c=%0d got=%b exp=%b", c, out_valid, m_full); end
      if (m_full) begin
        n_chk++; if (out_data !== m_data) begin n_fail++; $display("FAIL rand_data c=%0d got=%h exp=%h", c, out_data, m_data); end
`ifdef RR_MUX_CHID_EN
        n_chk++; if (out_ch !== SW'(m_ch)) begin n_fail++; $display("FAIL rand_ch c=%0d got=%0d exp=%0d", c, out_ch, m_ch); end
`endif
      end
    end
  endtask

  initial begin
    test_reset();
    test_fixed_sweep();
    test_rr_all();
    test_rr_sparse();
    test_backpressure();
    test_no_grant();
    test_reset_full();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
